add_sub_4bit: RTL and testbench



---
 rtl/add_sub_4bit_pkg.sv | 18 +
 rtl/add_sub_4bit_full_adder_1bit.sv | 23 ++
 rtl/add_sub_4bit.sv | 71 +++++++
 tb/tb_add_sub_4bit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/add_sub_4bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_4bit_pkg
// Brief    : Shared constants for the 4-bit signed adder/subtractor:
//            datapath width and the saturation limits.
// Revision : 1.0 - initial release
// ============================================================================
package add_sub_4bit_pkg;

  // Datapath width of the arithmetic primitive
  localparam int unsigned c_width = 4;

  // Two's-complement limits used when saturating on overflow
  localparam logic [c_width-1:0] c_sat_pos = 4'b0111;  // +7
  localparam logic [c_width-1:0] c_sat_neg = 4'b1000;  // -8

endpackage : add_sub_4bit_pkg
`default_nettype wire

// File: rtl/add_sub_4bit_full_adder_1bit.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_1bit
// Brief    : Single-bit full adder; one stage of the ripple-carry chain.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  // Propagate term shared by sum and carry
  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule : full_adder_1bit
`default_nettype wire

// File: rtl/add_sub_4bit.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_4bit
// Brief    : Registered 4-bit signed adder/subtractor built from a ripple
//            chain of full adders, with a registered signed-overflow flag.
//            Optional macro ADDSUB_SAT_EN saturates Sum to +7/-8 on
//            overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_4bit
  import add_sub_4bit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [c_width-1:0] A,
  input  logic [c_width-1:0] B,
  input  logic               sub,
  output logic [c_width-1:0] Sum,
  output logic               Ovfl
);

  logic [c_width-1:0] w_b;      // B, inverted when subtracting
  logic [c_width:0]   w_c;      // carry chain; w_c[i] is carry into bit i
  logic [c_width-1:0] w_raw;    // wrapped modulo-16 result
  logic [c_width-1:0] w_sum;    // result presented to the output register
  logic               w_ovfl;

  logic [c_width-1:0] r_sum;
  logic               r_ovfl;

  // Subtraction is A + ~B + 1: invert B and inject sub as carry-in
  assign w_b    = B ^ {c_width{sub}};
  assign w_c[0] = sub;

  // Ripple chain of full adders
  for (genvar i = 0; i < c_width; i++) begin : g_fa
    full_adder_1bit u_fa (
      .a    (A[i]),
      .b    (w_b[i]),
      .cin  (w_c[i]),
      .s    (w_raw[i]),
      .cout (w_c[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it
  assign w_ovfl = w_c[c_width-1] ^ w_c[c_width];

`ifdef ADDSUB_SAT_EN
  // On overflow the true result has the sign of A, so A[3] picks the limit
  assign w_sum = w_ovfl ? (A[c_width-1] ? c_sat_neg : c_sat_pos) : w_raw;
`else
  assign w_sum = w_raw;
`endif

  // Output registers load every cycle; async reset clears them immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_ovfl <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_ovfl <= w_ovfl;
    end
  end

  assign Sum  = r_sum;
  assign Ovfl = r_ovfl;

endmodule : add_sub_4bit
`default_nettype wire

// File: tb/tb_add_sub_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_sub_4bit
// Brief    : Self-checking bench for add_sub_4bit: reset, directed
//            arithmetic, overflow and boundary vectors, and an exhaustive
//            back-to-back sweep with a mid-sweep asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_sub_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       sub;
  logic [3:0] Sum;
  logic       Ovfl;

  int checks   = 0;
  int failures = 0;

  add_sub_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .sub   (sub),
    .Sum   (Sum),
    .Ovfl  (Ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operation at the falling edge, return 1 time unit after the
  // rising edge that captures it
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic s);
    @(negedge clk);
    A   = a;
    B   = b;
    sub = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'd3, 4'd2, 1'b0);
    checks++;
    if (Sum !== 4'd5) begin
      failures++;
      $display("FAIL pre_reset_sum got=%b want=%b", Sum, 4'd5);
    end
    // Assert reset mid-cycle, well away from any clock edge
    #2;
    rst_n = 1'b0;
    A = 4'd7; B = 4'd7; sub = 1'b0;
    #1;
    checks++;
    if (Sum !== 4'd0 || Ovfl !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%b/%b want=0000/0", Sum, Ovfl);
    end
    // Hold through a clock edge with overflowing inputs
    @(posedge clk);
    #1;
    checks++;
    if (Sum !== 4'd0 || Ovfl !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got=%b/%b want=0000/0", Sum, Ovfl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    A = 4'd1; B = 4'd1; sub = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (Sum !== 4'd2 || Ovfl !== 1'b0) begin
      failures++;
      $display("FAIL first_after_reset got=%b/%b want=0010/0", Sum, Ovfl);
    end
  endtask

  task automatic test_plain();
    drive(4'd3, 4'd2, 1'b0);
    checks++;
    if (Sum !== 4'b0101 || Ovfl !== 1'b0) begin
      failures++;
      $display("FAIL add_3_2 got=%b/%b want=0101/0", Sum, Ovfl);
    end
    drive(4'd3, 4'd5, 1'b1);
    checks++;
    if (Sum !== 4'b1110 || Ovfl !== 1'b0) begin
      failures++;
      $display("FAIL sub_3_5 got=%b/%b want=1110/0", Sum, Ovfl);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] exp_pos;
    logic [3:0] exp_neg;
`ifdef ADDSUB_SAT_EN
    exp_pos = 4'b0111;
    exp_neg = 4'b1000;
`else
    exp_pos = 4'b1000;
    exp_neg = 4'b0111;
`endif
    drive(4'd7, 4'd1, 1'b0);
    checks++;
    if (Sum !== exp_pos || Ovfl !== 1'b1) begin
      failures++;
      $display("FAIL pos_ovfl got=%b/%b want=%b/1", Sum, Ovfl, exp_pos);
    end
    drive(4'b1000, 4'd1, 1'b1);
    checks++;
    if (Sum !== exp_neg || Ovfl !== 1'b1) begin
      failures++;
      $display("FAIL neg_ovfl got=%b/%b want=%b/1", Sum, Ovfl, exp_neg);
    end
  endtask

  task automatic test_boundaries();
    drive(4'b1100, 4'b1100, 1'b0);
    checks++;
    if (Sum !== 4'b1000 || Ovfl !== 1'b0) begin
      failures++;
      $display("FAIL add_m4_m4 got=%b/%b want=1000/0", Sum, Ovfl);
    end
    drive(4'b1111, 4'b1000, 1'b1);
    checks++;
    if (Sum !== 4'b0111 || Ovfl !== 1'b0) begin
      failures++;
      $display("FAIL sub_m1_m8 got=%b/%b want=0111/0", Sum, Ovfl);
    end
  endtask

  task automatic test_back_to_back();
    int         ai;
    int         bi;
    int         res;
    logic [3:0] exp_sum;
    logic       exp_ovf;
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    for (int k = 0; k < 512; k++) begin
      a  = k[3:0];
      b  = k[7:4];
      s  = k[8];
      ai = a[3] ? int'(a) - 16 : int'(a);
      bi = b[3] ? int'(b) - 16 : int'(b);
      res = s ? ai - bi : ai + bi;
      exp_ovf = (res > 7) || (res < -8);
`ifdef ADDSUB_SAT_EN
      if (res > 7)       exp_sum = 4'b0111;
      else if (res < -8) exp_sum = 4'b1000;
      else               exp_sum = res[3:0];
`else
      exp_sum = res[3:0];
`endif
      drive(a, b, s);
      checks++;
      if (Sum !== exp_sum || Ovfl !== exp_ovf) begin
        failures++;
        $display("FAIL sweep a=%b b=%b sub=%b got=%b/%b want=%b/%b",
                 a, b, s, Sum, Ovfl, exp_sum, exp_ovf);
      end
      if (k == 300) begin
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Sum !== 4'd0 || Ovfl !== 1'b0) begin
          failures++;
          $display("FAIL sweep_reset got=%b/%b want=0000/0", Sum, Ovfl);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    A     = 4'd0;
    B     = 4'd0;
    sub   = 1'b0;
    test_reset();
    test_plain();
    test_overflow();
    test_boundaries();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_add_sub_4bit
`default_nettype wire
